// File: rtl/plant_defender.sv
// plant_defender: per-lane plant slot with health, zombie halt coordinate and pea shooter.
module plant_defender #(
    parameter logic [9:0] HALF_W      = 10'd20,
    parameter logic [3:0] MAX_HP      = 4'd10,
    parameter logic [5:0] BITE_FRAMES = 6'd30,
    parameter logic [5:0] COOLDOWN    = 6'd60,
    parameter logic [7:0] FIRE_PERIOD = 8'd90,
    parameter logic [9:0] PEA_STEP    = 10'd4,
    parameter logic [9:0] X_Max       = 10'd639
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       place,
    input  logic [9:0] slotX,
    input  logic [9:0] slotY,
    input  logic       eat,
    input  logic       hit,
    output logic       PlantLive,
    output logic [9:0] PlantX,
    output logic [9:0] PlantY,
    output logic [9:0] stopX,
    output logic [3:0] health,
    output logic       died,
    output logic       peaLive,
    output logic [9:0] peaX,
    output logic [9:0] peaY
);
    typedef enum logic [1:0] {EMPTY, LIVE, DEAD} state_t;
    state_t state, state_nxt;
    logic [5:0] bite_cnt, cool_cnt;
    logic [7:0] fire_cnt;
    logic bite, death, wrap, launch;
    always_comb begin
        bite      = state == LIVE && eat && bite_cnt == BITE_FRAMES - 6'd1;
        death     = bite && health == 4'd1;
        wrap      = state == LIVE && fire_cnt == FIRE_PERIOD - 8'd1;
        launch    = wrap && !peaLive && !death;
        state_nxt = state == EMPTY ? (place ? LIVE : EMPTY) :
                    state == LIVE  ? (death ? DEAD : LIVE) :
                    (cool_cnt == COOLDOWN - 6'd1 ? EMPTY : DEAD);
    end
    always_ff @(posedge frame_clk or negedge Reset_n)
        if (!Reset_n) state <= EMPTY;
        else state <= state_nxt;
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PlantLive <= 1'b0;
            PlantX    <= 10'd0;
            PlantY    <= 10'd0;
            stopX     <= 10'd1023;
            health    <= 4'd0;
            died      <= 1'b0;
            bite_cnt  <= 6'd0;
            fire_cnt  <= 8'd0;
            cool_cnt  <= 6'd0;
            peaLive   <= 1'b0;
            peaX      <= 10'd0;
            peaY      <= 10'd0;
        end else begin
            PlantLive <= state_nxt == LIVE;
            died      <= death;
            if (state == EMPTY && place) begin
                PlantX   <= slotX;
                PlantY   <= slotY;
                stopX    <= slotX + HALF_W;
                health   <= MAX_HP;
                bite_cnt <= 6'd0;
                fire_cnt <= 8'd0;
            end else if (state == LIVE) begin
                if (eat) bite_cnt <= bite ? 6'd0 : bite_cnt + 6'd1;
                if (bite) health <= health - 4'd1;
                fire_cnt <= wrap ? 8'd0 : fire_cnt + 8'd1;
                if (death) begin
                    stopX    <= 10'd1023;
                    cool_cnt <= 6'd0;
                end
            end else if (state == DEAD) begin
                cool_cnt <= cool_cnt + 6'd1;
            end
            // the pea flies on its own once launched, regardless of plant state
            if (peaLive) begin
                if (hit || peaX > X_Max - PEA_STEP) peaLive <= 1'b0;
                else peaX <= peaX + PEA_STEP;
            end else if (launch) begin
                peaLive <= 1'b1;
                peaX    <= PlantX + HALF_W;
                peaY    <= PlantY;
            end
        end
    end
endmodule

// File: tb/tb_plant_defender.sv
// tb_plant_defender: directed checks of placement, bites, death/cooldown, pea flight and async reset.
module tb_plant_defender;
    logic       frame_clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       place = 1'b0;
    logic [9:0] slotX = 10'd0;
    logic [9:0] slotY = 10'd0;
    logic       eat = 1'b0;
    logic       hit = 1'b0;
    logic       PlantLive, died, peaLive;
    logic [9:0] PlantX, PlantY, stopX, peaX, peaY;
    logic [3:0] health;
    int checks = 0;
    int errors = 0;

    plant_defender dut (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .place(place), .slotX(slotX), .slotY(slotY),
        .eat(eat), .hit(hit), .PlantLive(PlantLive), .PlantX(PlantX), .PlantY(PlantY),
        .stopX(stopX), .health(health), .died(died), .peaLive(peaLive), .peaX(peaX), .peaY(peaY)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        tk(2);
        chk("rst_live", PlantLive, 0);
        chk("rst_stopx", stopX, 1023);
        chk("rst_health", health, 0);
        chk("rst_pea", peaLive, 0);
        chk("rst_died", died, 0);
        Reset_n = 1'b1;
        place = 1'b1; slotX = 10'd100; slotY = 10'd200;
        tk(1);
        place = 1'b0;
        chk("place_live", PlantLive, 1);
        chk("place_stopx", stopX, 120);
        chk("place_health", health, 10);
        chk("place_x", PlantX, 100);
        chk("place_y", PlantY, 200);
        eat = 1'b1;
        tk(29);
        chk("bite29_health", health, 10);
        eat = 1'b0;
        tk(10);
        chk("gap_health", health, 10);
        eat = 1'b1;
        tk(1);
        chk("bite30_health", health, 9);
        tk(50);
        chk("launch_live", peaLive, 1);
        chk("launch_x", peaX, 120);
        chk("launch_y", peaY, 200);
        chk("e90_health", health, 8);
        tk(90);
        chk("skip_live", peaLive, 1);
        chk("skip_x", peaX, 480);
        tk(39);
        chk("far_x", peaX, 636);
        chk("far_live", peaLive, 1);
        tk(1);
        chk("exit1_live", peaLive, 0);
        chk("exit1_hold", peaX, 636);
        tk(89);
        chk("predeath_health", health, 1);
        chk("predeath_died", died, 0);
        chk("predeath_live", PlantLive, 1);
        tk(1);
        chk("death_died", died, 1);
        chk("death_live", PlantLive, 0);
        chk("death_stopx", stopX, 1023);
        chk("death_health", health, 0);
        eat = 1'b0;
        place = 1'b1; slotX = 10'd600; slotY = 10'd50;
        tk(1);
        chk("died_pulse_end", died, 0);
        chk("cool_live1", PlantLive, 0);
        tk(59);
        chk("cool_live60", PlantLive, 0);
        tk(1);
        chk("replace_live", PlantLive, 1);
        chk("replace_stopx", stopX, 620);
        chk("replace_health", health, 10);
        place = 1'b0;
        tk(89);
        chk("p89_pea", peaLive, 0);
        tk(1);
        chk("p90_pea", peaLive, 1);
        chk("p90_x", peaX, 620);
        chk("p90_y", peaY, 50);
        tk(4);
        chk("p94_x", peaX, 636);
        chk("p94_live", peaLive, 1);
        tk(1);
        chk("p95_live", peaLive, 0);
        chk("p95_hold", peaX, 636);
        Reset_n = 1'b0;
        tk(1);
        chk("rst2_live", PlantLive, 0);
        chk("rst2_peax", peaX, 0);
        Reset_n = 1'b1;
        place = 1'b1; slotX = 10'd100; slotY = 10'd300;
        tk(1);
        place = 1'b0;
        eat = 1'b1;
        chk("q_live", PlantLive, 1);
        chk("q_x", PlantX, 100);
        tk(150);
        chk("q150_health", health, 5);
        eat = 1'b0;
        tk(29);
        chk("q179_x", peaX, 476);
        chk("q179_live", peaLive, 1);
        hit = 1'b1;
        tk(1);
        hit = 1'b0;
        chk("hitwrap_live", peaLive, 0);
        chk("hitwrap_x", peaX, 476);
        tk(89);
        chk("q269_live", peaLive, 0);
        tk(1);
        chk("q270_live", peaLive, 1);
        chk("q270_x", peaX, 120);
        chk("q270_y", peaY, 300);
        chk("q270_health", health, 5);
        #3 Reset_n = 1'b0;
        #1;
        chk("arst_live", PlantLive, 0);
        chk("arst_health", health, 0);
        chk("arst_pea", peaLive, 0);
        chk("arst_peax", peaX, 0);
        chk("arst_stopx", stopX, 1023);
        chk("arst_died", died, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/plant_defender.md
# plant_defender

Per-lane plant controller: the stationary counterpart to the zombie motion block. It owns one plant slot, publishes the halt coordinate `stopX` that a zombie stops at, and consumes the zombie's `eat` level to drain plant health. While alive it fires a pea projectile that travels in the opposite direction to the zombie, rightward in +X, until it hits or leaves the screen. It sits between the placement/mouse logic and the zombie motion and collision blocks, and all of its outputs feed the sprite renderer.

## Interface
Parameters:
- HALF_W, 10'd20: half plant width; the plant's right edge is PlantX + HALF_W.
- MAX_HP, 4'd10: health loaded on placement.
- BITE_FRAMES, 6'd30: frames of asserted `eat` per 1 HP lost.
- COOLDOWN, 6'd60: frames in DEAD before the slot is reusable.
- FIRE_PERIOD, 8'd90: frames between shot attempts.
- PEA_STEP, 10'd4: pea X increment per frame.
- X_Max, 10'd639: rightmost screen X.

Ports:
- frame_clk, in, 1: frame clock, the sole clock.
- Reset_n, in, 1: reset, asynchronous and active-low.
- place, in, 1: plant request, sampled only in EMPTY.
- slotX, in, 10: placement center X.
- slotY, in, 10: placement center Y.
- eat, in, 1: zombie is eating this plant (level).
- hit, in, 1: the pea has collided with a zombie.
- PlantLive, out, 1: plant present.
- PlantX, out, 10: latched plant center X.
- PlantY, out, 10: latched plant center Y.
- stopX, out, 10: zombie halt coordinate.
- health, out, 4: remaining HP.
- died, out, 1: one-frame pulse on death.
- peaLive, out, 1: pea in flight.
- peaX, out, 10: pea position X.
- peaY, out, 10: pea position Y.

## Operation
- FSM states: EMPTY, LIVE, DEAD.
- Reset (Reset_n=0, async) sets:
  - state EMPTY, PlantLive 0, PlantX/PlantY 0, health 0, stopX 10'd1023, died 0.
  - peaLive 0, peaX/peaY 0, bite counter 0, fire counter 0, cooldown counter 0.
  - A reset mid-flight or mid-bite discards everything.
- EMPTY:
  - With place=1: latch slotX/slotY, health←MAX_HP, bite and fire counters←0, go to LIVE.
  - Otherwise stay in EMPTY.
- LIVE:
  - place is ignored.
  - stopX = PlantX + HALF_W (10-bit, registered). In EMPTY and DEAD, stopX = 10'd1023.
  - Bite counter increments on each frame with eat=1. It holds its value when eat=0, so partial bites are not forgiven.
  - When eat=1 and the counter = BITE_FRAMES−1: counter←0 and health←health−1.
  - If that bite takes health from 1 to 0: health←0, died←1 for one frame, cooldown←0, go to DEAD.
- DEAD:
  - PlantLive 0; place and eat are ignored.
  - The cooldown counter increments each frame. At COOLDOWN−1 the FSM goes to EMPTY.
- Fire counter:
  - Counts only in LIVE and wraps at FIRE_PERIOD−1.
  - On the wrap frame, if peaLive=0: peaLive←1, peaX←PlantX+HALF_W, peaY←PlantY.
  - If peaLive=1 on the wrap frame, the shot is skipped and the counter still wraps.
- Pea flight, evaluated when peaLive=1, in priority order:
  1. hit=1 → peaLive←0.
  2. Else peaX > X_Max−PEA_STEP → peaLive←0 (this form avoids 10-bit overflow).
  3. Else peaX←peaX+PEA_STEP.
- peaX and peaY hold their values while peaLive=0.
- The pea keeps flying after the plant dies, and stays independent of the DEAD and EMPTY states.
- Simultaneous events:
  - hit on the fire-wrap frame: the pea retires and no launch happens that frame.
  - The final bite and the fire wrap in the same frame: death wins and no launch happens.

## Timing
- All outputs are registered and update on posedge frame_clk. There are no combinational paths from inputs to outputs.
- place → PlantLive=1 and stopX valid after 1 edge.
- First launch: peaLive rises FIRE_PERIOD edges after PlantLive rises. Subsequent launches follow every FIRE_PERIOD edges if the pea has retired.
- With eat held continuously:
  - HP drops every BITE_FRAMES edges.
  - died pulses MAX_HP·BITE_FRAMES edges after eat first asserts.
  - PlantLive falls on the same edge as the died pulse.
- A new place is accepted COOLDOWN edges after entering DEAD, plus 1 edge in EMPTY.

## Test plan
- Reset, then placement: release Reset_n, place=1 with slotX=100, slotY=200 → next edge PlantLive=1, stopX=120, health=10, PlantY=200.
- Bite accounting: hold eat=1 for 29 frames, drop it for 10, then assert 1 more → health stays 10 through the first 29 frames, becomes 9 after the 30th asserted frame, and the bite counter holds during the gap.
- Death and cooldown: hold eat=1 for 300 frames → died pulses exactly once, PlantLive=0, stopX=1023. place is ignored for 60 frames, then accepted on the first frame in EMPTY.
- Pea launch and edge exit: plant at X=600 with no hit → peaLive rises at frame 90 with peaX=620, steps 624…636, and retires the frame after 636 (636 > 635).
- Hit and skip: pea in flight with hit=1 on the fire-wrap frame → peaLive=0 and no relaunch until the next period. With the pea still live on a wrap frame, the shot is skipped.
- Async reset mid-flight: Reset_n low between edges with the pea live and health=5 → all outputs return to reset values immediately, without waiting for a clock edge.
